ra_parser: RTL

RA_PARSER -- requirements
Module: ra_parser

---
 rtl/pvr_pkg.sv | 32 +++
 rtl/ra_parser_if.sv | 53 +++++
 rtl/ra_parser.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pvr_pkg.sv
// Shared definitions for the region-array parser: control-word layout,
// entry sizes, the empty-list pointer value and the walker state type.
package pvr_pkg;

    localparam int unsigned CTRL_LAST_BIT    = 31;
    localparam int unsigned CTRL_ZCLEAR_BIT  = 30;
    localparam int unsigned CTRL_PRESORT_BIT = 29;
    localparam int unsigned CTRL_FLUSH_BIT   = 28;
    localparam int unsigned TILEY_MSB        = 13;
    localparam int unsigned TILEY_LSB        = 8;
    localparam int unsigned TILEX_MSB        = 7;
    localparam int unsigned TILEX_LSB        = 2;

    localparam int unsigned WORDS_V1 = 5;
    localparam int unsigned WORDS_V2 = 6;

    localparam logic [31:0] PTR_EMPTY = 32'h8000_0000;

    typedef enum logic [2:0] {
        RA_IDLE,
        RA_REQ,
        RA_WAIT,
        RA_PRESENT,
        RA_DONE
    } ra_state_e;

    // Index of the final word of an entry for the selected format.
    function automatic logic [2:0] last_word_idx(input logic fmt_v2);
        return fmt_v2 ? 3'(WORDS_V2 - 1) : 3'(WORDS_V1 - 1);
    endfunction

endpackage

// File: rtl/ra_parser_if.sv
// Signal bundle of the region-array parser: start/config, VRAM read bus and
// the decoded entry handed to the object-list parser.
interface ra_parser_if;

    logic        ra_start;
    logic [23:0] ra_region_base;
    logic        ra_fmt_v2;

    logic        ra_vram_rd;
    logic [23:0] ra_vram_addr;
    logic [31:0] ra_vram_din;
    logic        ra_vram_valid;

    logic        ra_entry_valid;
    logic        ol_ready;
    logic        ra_cont_last;
    logic        ra_cont_zclear;
    logic        ra_cont_presort;
    logic        ra_cont_flush;
    logic [5:0]  ra_cont_tiley;
    logic [5:0]  ra_cont_tilex;
    logic [31:0] ra_opaque;
    logic [31:0] ra_opaque_mod;
    logic [31:0] ra_trans;
    logic [31:0] ra_trans_mod;
    logic [31:0] ra_puncht;

    logic        ra_busy;
    logic        ra_done;

    // Parser side: masters the VRAM bus and produces entries.
    modport master (
        input  ra_start, ra_region_base, ra_fmt_v2,
        input  ra_vram_din, ra_vram_valid, ol_ready,
        output ra_vram_rd, ra_vram_addr,
        output ra_entry_valid, ra_cont_last, ra_cont_zclear, ra_cont_presort,
        output ra_cont_flush, ra_cont_tiley, ra_cont_tilex,
        output ra_opaque, ra_opaque_mod, ra_trans, ra_trans_mod, ra_puncht,
        output ra_busy, ra_done
    );

    // Environment side: host, VRAM and downstream consumer.
    modport slave (
        output ra_start, ra_region_base, ra_fmt_v2,
        output ra_vram_din, ra_vram_valid, ol_ready,
        input  ra_vram_rd, ra_vram_addr,
        input  ra_entry_valid, ra_cont_last, ra_cont_zclear, ra_cont_presort,
        input  ra_cont_flush, ra_cont_tiley, ra_cont_tilex,
        input  ra_opaque, ra_opaque_mod, ra_trans, ra_trans_mod, ra_puncht,
        input  ra_busy, ra_done
    );

endinterface

// File: rtl/ra_parser.sv
// Region-array walker: fetches 5- or 6-word entries from VRAM one word at a
// time, presents each decoded entry until accepted, and stops after the
// entry whose control word carries the last flag.
module ra_parser
    import pvr_pkg::*;
(
    input logic        clock,
    input logic        reset,
    ra_parser_if.master bus
);

    ra_state_e   state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic [2:0]  idx_q, idx_d;
    logic        v2_q, v2_d;
    // Only the decoded control bits are kept: {last, zclear, presort, flush, tiley, tilex}.
    logic [15:0] ctrl_q, ctrl_d;
    // Pointer words 1..5 of the entry live in slots 0..4.
    logic [31:0] ptr_q [WORDS_V2-1];
    logic [31:0] ptr_d [WORDS_V2-1];

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RA_IDLE;
            addr_q  <= '0;
            idx_q   <= '0;
            v2_q    <= 1'b0;
            ctrl_q  <= '0;
            ptr_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            v2_q    <= v2_d;
            ctrl_q  <= ctrl_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state and datapath update for the fetch/present walk.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        v2_d    = v2_q;
        ctrl_d  = ctrl_q;
        ptr_d   = ptr_q;

        unique case (state_q)
            RA_IDLE: begin
                if (bus.ra_start) begin
                    addr_d  = bus.ra_region_base;
                    idx_d   = '0;
                    v2_d    = bus.ra_fmt_v2;
                    // v1 entries carry no puncht word, so it reads as an empty list.
                    if (!bus.ra_fmt_v2) begin
                        ptr_d[WORDS_V2-2] = PTR_EMPTY;
                    end
                    state_d = RA_REQ;
                end
            end
            RA_REQ: begin
                state_d = RA_WAIT;
            end
            RA_WAIT: begin
                if (bus.ra_vram_valid) begin
                    if (idx_q == '0) begin
                        ctrl_d = {bus.ra_vram_din[CTRL_LAST_BIT],
                                  bus.ra_vram_din[CTRL_ZCLEAR_BIT],
                                  bus.ra_vram_din[CTRL_PRESORT_BIT],
                                  bus.ra_vram_din[CTRL_FLUSH_BIT],
                                  bus.ra_vram_din[TILEY_MSB:TILEY_LSB],
                                  bus.ra_vram_din[TILEX_MSB:TILEX_LSB]};
                    end
                    for (int unsigned i = 1; i < WORDS_V2; i++) begin
                        if (idx_q == 3'(i)) begin
                            ptr_d[i-1] = bus.ra_vram_din;
                        end
                    end
                    addr_d = addr_q + 24'd4;
                    if (idx_q == last_word_idx(v2_q)) begin
                        state_d = RA_PRESENT;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = RA_REQ;
                    end
                end
            end
            RA_PRESENT: begin
                if (bus.ol_ready) begin
                    if (ctrl_q[15]) begin
                        state_d = RA_DONE;
                    end else begin
                        idx_d   = '0;
                        state_d = RA_REQ;
                    end
                end
            end
            RA_DONE: begin
                state_d = RA_IDLE;
            end
            default: begin
                state_d = RA_IDLE;
            end
        endcase
    end

    assign bus.ra_vram_rd      = (state_q == RA_REQ);
    assign bus.ra_vram_addr    = addr_q;
    assign bus.ra_entry_valid  = (state_q == RA_PRESENT);
    assign bus.ra_busy         = (state_q != RA_IDLE);
    assign bus.ra_done         = (state_q == RA_DONE);

    assign bus.ra_cont_last    = ctrl_q[15];
    assign bus.ra_cont_zclear  = ctrl_q[14];
    assign bus.ra_cont_presort = ctrl_q[13];
    assign bus.ra_cont_flush   = ctrl_q[12];
    assign bus.ra_cont_tiley   = ctrl_q[11:6];
    assign bus.ra_cont_tilex   = ctrl_q[5:0];

    assign bus.ra_opaque       = ptr_q[0];
    assign bus.ra_opaque_mod   = ptr_q[1];
    assign bus.ra_trans        = ptr_q[2];
    assign bus.ra_trans_mod    = ptr_q[3];
    assign bus.ra_puncht       = ptr_q[4];

endmodule
